// File: rtl/stream_compare.sv
// stream_compare: registered six-flag signed/unsigned comparator on a valid/ready stream with saturating pair/equal counters.
// Define STREAM_COMPARE_MINMAX_EN to add registered min_out/max_out ports.
module stream_compare #(
  parameter int WIDTH = 8,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 signed_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [5:0]           y,
  input  logic                 clear_count,
  output logic [CNT_WIDTH-1:0] pair_count,
  output logic [CNT_WIDTH-1:0] eq_count
`ifdef STREAM_COMPARE_MINMAX_EN
  ,
  output logic [WIDTH-1:0]     min_out,
  output logic [WIDTH-1:0]     max_out
`endif
);
  logic [WIDTH-1:0] flip, ax, bx;
  logic eq, gt, lt, acc;
  // Flipping the sign bit maps two's-complement order onto unsigned order
  always_comb begin
    flip = '0;
    flip[WIDTH-1] = signed_mode;
    ax = a ^ flip;
    bx = b ^ flip;
    eq = a == b;
    gt = ax > bx;
    lt = ax < bx;
  end
  assign in_ready = !out_valid || out_ready;
  assign acc = in_valid && in_ready;
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      y <= '0;
    end else if (acc) begin
      out_valid <= 1'b1;
      y <= {eq, !eq, gt, lt, gt | eq, lt | eq};
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset || clear_count) begin
      pair_count <= '0;
      eq_count <= '0;
    end else if (acc) begin
      pair_count <= pair_count + CNT_WIDTH'(pair_count != '1);
      eq_count <= eq_count + CNT_WIDTH'(eq && eq_count != '1);
    end
  end
`ifdef STREAM_COMPARE_MINMAX_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      min_out <= '0;
      max_out <= '0;
    end else if (acc) begin
      min_out <= lt ? a : b;
      max_out <= gt ? a : b;
    end
  end
`endif
endmodule

// File: tb/tb_stream_compare.sv
// tb_stream_compare: directed literal checks plus randomized stream checked every cycle against a transaction-level model.
module tb_stream_compare;
  logic clk = 1'b0;
  logic reset, in_valid, signed_mode, out_ready, clear_count;
  logic [7:0] a, b;
  logic in_ready, out_valid, in_ready2, out_valid2, in_ready1, out_valid1;
  logic [5:0] y, y2, y1;
  logic [7:0] pc, ec;
  logic [1:0] pc2, ec2, pc1, ec1;
  logic a1, b1;
`ifdef STREAM_COMPARE_MINMAX_EN
  logic [7:0] mn, mx, mn2, mx2;
  logic mn1, mx1;
`endif
  assign a1 = a[0];
  assign b1 = b[0];
  always #5 clk = ~clk;

  stream_compare #(.WIDTH(8), .CNT_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .signed_mode(signed_mode), .out_valid(out_valid), .out_ready(out_ready), .y(y),
    .clear_count(clear_count), .pair_count(pc), .eq_count(ec)
`ifdef STREAM_COMPARE_MINMAX_EN
    , .min_out(mn), .max_out(mx)
`endif
  );
  stream_compare #(.WIDTH(8), .CNT_WIDTH(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2), .a(a), .b(b),
    .signed_mode(signed_mode), .out_valid(out_valid2), .out_ready(out_ready), .y(y2),
    .clear_count(clear_count), .pair_count(pc2), .eq_count(ec2)
`ifdef STREAM_COMPARE_MINMAX_EN
    , .min_out(mn2), .max_out(mx2)
`endif
  );
  stream_compare #(.WIDTH(1), .CNT_WIDTH(2)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1), .a(a1), .b(b1),
    .signed_mode(signed_mode), .out_valid(out_valid1), .out_ready(out_ready), .y(y1),
    .clear_count(clear_count), .pair_count(pc1), .eq_count(ec1)
`ifdef STREAM_COMPARE_MINMAX_EN
    , .min_out(mn1), .max_out(mx1)
`endif
  );

  int errors = 0, checks = 0;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  function automatic int interp(input logic [7:0] x, input bit s, input int w);
    int v = int'(x) & ((1 << w) - 1);
    if (s && v >= (1 << (w - 1))) v -= (1 << w);
    return v;
  endfunction
  function automatic logic [5:0] flags(input int av, input int bv);
    return {av == bv, av != bv, av > bv, av < bv, av >= bv, av <= bv};
  endfunction
  function automatic int sat(input int c, input int w);
    return c < (1 << w) - 1 ? c + 1 : c;
  endfunction

  // Transaction-level model: a single result slot plus accepted-pair tallies
  bit started = 0, m_valid = 0;
  logic [5:0] m_y = '0, m_y1 = '0;
  logic [7:0] m_min = '0, m_max = '0;
  int m_pc = 0, m_ec = 0, m_pc2 = 0, m_ec2 = 0, m_ec1 = 0;
  always @(posedge clk) begin
    if (reset) begin
      started = 1;
      m_valid = 0; m_y = '0; m_y1 = '0; m_min = '0; m_max = '0;
      m_pc = 0; m_ec = 0; m_pc2 = 0; m_ec2 = 0; m_ec1 = 0;
    end else if (started) begin
      bit acc;
      int av, bv;
      acc = in_valid && (!m_valid || out_ready);
      av = interp(a, signed_mode, 8);
      bv = interp(b, signed_mode, 8);
      if (clear_count) begin
        m_pc = 0; m_ec = 0; m_pc2 = 0; m_ec2 = 0; m_ec1 = 0;
      end else if (acc) begin
        m_pc = sat(m_pc, 8);
        m_pc2 = sat(m_pc2, 2);
        if (a == b) begin m_ec = sat(m_ec, 8); m_ec2 = sat(m_ec2, 2); end
        if (a[0] == b[0]) m_ec1 = sat(m_ec1, 2);
      end
      if (acc) begin
        m_valid = 1;
        m_y = flags(av, bv);
        m_y1 = flags(interp({7'b0, a[0]}, signed_mode, 1), interp({7'b0, b[0]}, signed_mode, 1));
        m_min = av <= bv ? a : b;
        m_max = av >= bv ? a : b;
      end else if (out_ready) m_valid = 0;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("in_ready", in_ready, !m_valid || out_ready);
      chk("out_valid", out_valid, m_valid);
      chk("y", y, m_y);
      chk("pair_count", pc, m_pc);
      chk("eq_count", ec, m_ec);
      chk("out_valid2", out_valid2, m_valid);
      chk("y2", y2, m_y);
      chk("pair_count2", pc2, m_pc2);
      chk("eq_count2", ec2, m_ec2);
      chk("out_valid1", out_valid1, m_valid);
      chk("y1", y1, m_y1);
      chk("pair_count1", pc1, m_pc2);
      chk("eq_count1", ec1, m_ec1);
`ifdef STREAM_COMPARE_MINMAX_EN
      chk("min_out", mn, m_min);
      chk("max_out", mx, m_max);
`endif
    end
  end

  task automatic cyc(input bit iv, input logic [7:0] av, input logic [7:0] bv, input bit s,
                     input bit ordy, input bit clr);
    #1;
    in_valid = iv; a = av; b = bv; signed_mode = s; out_ready = ordy; clear_count = clr;
    @(negedge clk);
  endtask

  initial begin
    reset = 1; in_valid = 0; a = 0; b = 0; signed_mode = 0; out_ready = 0; clear_count = 0;
    repeat (2) @(negedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("lit_reset_in_ready", in_ready, 1);
    chk("lit_reset_y", y, 0);
    cyc(1, 8'h80, 8'h7f, 0, 1, 0);
    chk("lit_unsigned_80_7f", y, 6'b011010);
    cyc(1, 8'h80, 8'h7f, 1, 1, 0);
    chk("lit_signed_80_7f", y, 6'b010101);
    chk("lit_pc2", pc, 2);
    cyc(1, 8'h80, 8'h7f, 0, 1, 1);
    chk("lit_clear_pc", pc, 0);
    chk("lit_clear_ec", ec, 0);
    chk("lit_clear_valid", out_valid, 1);
    chk("lit_clear_y", y, 6'b011010);
    cyc(1, 8'h3c, 8'h3c, 0, 1, 0);
    chk("lit_eq_y", y, 6'b100011);
    chk("lit_eq_pc", pc, 1);
    chk("lit_eq_ec", ec, 1);
    cyc(1, 8'h01, 8'h02, 0, 1, 0);
    chk("lit_bp_first", y, 6'b010101);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 8'h05, 8'h05, 0, 0, 0);
      chk("lit_bp_hold_y", y, 6'b010101);
      chk("lit_bp_in_ready", in_ready, 0);
      chk("lit_bp_pc", pc, 2);
    end
    cyc(1, 8'h05, 8'h05, 0, 1, 0);
    chk("lit_bp_release_y", y, 6'b100011);
    chk("lit_bp_release_ec", ec, 2);
    cyc(1, 8'h01, 8'h00, 1, 1, 0);
    chk("lit_w1_signed", y1, 6'b010101);
    cyc(1, 8'h01, 8'h00, 0, 1, 0);
    chk("lit_w1_unsigned", y1, 6'b011010);
    cyc(0, 8'h00, 8'h00, 0, 1, 1);
    for (int i = 0; i < 5; i++) cyc(1, 8'(i), 8'(i), 0, 1, 0);
    chk("lit_sat_pc2", pc2, 3);
    chk("lit_sat_ec2", ec2, 3);
    chk("lit_sat_pc", pc, 5);
`ifdef STREAM_COMPARE_MINMAX_EN
    cyc(1, 8'hf0, 8'h10, 1, 1, 0);
    chk("lit_min", mn, 8'hf0);
    chk("lit_max", mx, 8'h10);
`endif
    cyc(1, 8'h04, 8'h04, 0, 0, 0);
    cyc(1, 8'h09, 8'h04, 0, 0, 0);
    #1 reset = 1;
    @(negedge clk);
    chk("lit_rst_valid", out_valid, 0);
    chk("lit_rst_y", y, 0);
    chk("lit_rst_pc", pc, 0);
    chk("lit_rst_in_ready", in_ready, 1);
`ifdef STREAM_COMPARE_MINMAX_EN
    chk("lit_rst_min", mn, 0);
    chk("lit_rst_max", mx, 0);
`endif
    #1 reset = 0;
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : 8'($urandom);
      #1 reset = ($urandom_range(0, 299) == 0);
      cyc($urandom_range(0, 3) != 0, ra, rb, 1'($urandom), $urandom_range(0, 2) != 0,
          $urandom_range(0, 99) == 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
